// File: rtl/draw_sequencer_pkg.sv
// Shared types and constants for the frame draw sequencer.
package draw_sequencer_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CLR    = 4'd1,
    CLRW   = 4'd2,
    BG     = 4'd3,
    LP     = 4'd4,
    RP     = 4'd5,
    BALL   = 4'd6,
    LG     = 4'd7,
    RG     = 4'd8,
    GND    = 4'd9,
    FINISH = 4'd10
  } state_t;

  localparam int unsigned NUM_STAGES = 7;

  localparam logic [2:0] STG_BG   = 3'd0;
  localparam logic [2:0] STG_LP   = 3'd1;
  localparam logic [2:0] STG_RP   = 3'd2;
  localparam logic [2:0] STG_BALL = 3'd3;
  localparam logic [2:0] STG_LG   = 3'd4;
  localparam logic [2:0] STG_RG   = 3'd5;
  localparam logic [2:0] STG_GND  = 3'd6;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 131072;

  function automatic logic is_stage(state_t s);
    return s inside {BG, LP, RP, BALL, LG, RG, GND};
  endfunction

  function automatic logic [2:0] stage_idx(state_t s);
    case (s)
      BG:      return STG_BG;
      LP:      return STG_LP;
      RP:      return STG_RP;
      BALL:    return STG_BALL;
      LG:      return STG_LG;
      RG:      return STG_RG;
      GND:     return STG_GND;
      default: return STG_BG;
    endcase
  endfunction

endpackage

// File: rtl/draw_sequencer_if.sv
// Request/done/clear handshake between the sequencer and the sprite datapath.
interface draw_sequencer_if;
  logic draw_bg, draw_lp, draw_rp, draw_ball, draw_lg, draw_rg, draw_gnd;
  logic done_bg, done_lp, done_rp, done_ball, done_lg, done_rg, done_gnd;
  logic dp_clear;

  modport master (
    output draw_bg, draw_lp, draw_rp, draw_ball, draw_lg, draw_rg, draw_gnd,
    output dp_clear,
    input  done_bg, done_lp, done_rp, done_ball, done_lg, done_rg, done_gnd
  );

  modport slave (
    input  draw_bg, draw_lp, draw_rp, draw_ball, draw_lg, draw_rg, draw_gnd,
    input  dp_clear,
    output done_bg, done_lp, done_rp, done_ball, done_lg, done_rg, done_gnd
  );
endinterface

// File: rtl/draw_sequencer_stage_watchdog.sv
// Per-stage watchdog: up-counter reloaded to zero on stage entry, flags its last allowed cycle.
module stage_watchdog
  import draw_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic clear,
  input  logic en,
  output logic terminal
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign terminal = en && (count == LAST);

endmodule

// File: rtl/draw_sequencer.sv
// Frame-level controller: clears the datapath, then walks the seven draw stages in order.
module draw_sequencer
  import draw_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned FRAME_W        = 8
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               enable,
  input  logic               frame_tick,
  draw_sequencer_if.master   dp,
  output logic               busy,
  output logic               frame_done,
  output logic [FRAME_W-1:0] frame_count,
  output logic               overrun,
  output logic               timeout_err
);

  state_t state, stateNext;
  logic [NUM_STAGES-1:0] doneVec, drawVec, drawNext;
  logic clearReg;
  logic inStage, doneSel, wdTerminal, wdClear, stageAdvance, stageTimeout;

  assign doneVec = {dp.done_gnd, dp.done_rg, dp.done_lg, dp.done_ball,
                    dp.done_rp, dp.done_lp, dp.done_bg};

  assign dp.draw_bg   = drawVec[STG_BG];
  assign dp.draw_lp   = drawVec[STG_LP];
  assign dp.draw_rp   = drawVec[STG_RP];
  assign dp.draw_ball = drawVec[STG_BALL];
  assign dp.draw_lg   = drawVec[STG_LG];
  assign dp.draw_rg   = drawVec[STG_RG];
  assign dp.draw_gnd  = drawVec[STG_GND];
  assign dp.dp_clear  = clearReg;

  always_comb begin
    inStage      = is_stage(state);
    doneSel      = inStage ? doneVec[stage_idx(state)] : 1'b0;
    stageAdvance = inStage && (doneSel || wdTerminal);
    stageTimeout = inStage && wdTerminal && !doneSel;

    stateNext = state;
    case (state)
      IDLE:    if (frame_tick && enable) stateNext = CLR;
      CLR:     stateNext = CLRW;
      CLRW:    stateNext = BG;
      BG:      if (stageAdvance) stateNext = LP;
      LP:      if (stageAdvance) stateNext = RP;
      RP:      if (stageAdvance) stateNext = BALL;
      BALL:    if (stageAdvance) stateNext = LG;
      LG:      if (stageAdvance) stateNext = RG;
      RG:      if (stageAdvance) stateNext = GND;
      GND:     if (stageAdvance) stateNext = FINISH;
      FINISH:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state register.
    drawNext = '0;
    if (is_stage(stateNext)) drawNext[stage_idx(stateNext)] = 1'b1;

    wdClear = is_stage(stateNext) && (stateNext != state);
  end

  stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uWatchdog (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .clear    (wdClear),
    .en       (inStage),
    .terminal (wdTerminal)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state       <= IDLE;
      drawVec     <= '0;
      clearReg    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state      <= stateNext;
      drawVec    <= drawNext;
      clearReg   <= (stateNext == CLR);
      busy       <= (stateNext != IDLE);
      frame_done <= (stateNext == FINISH);
      if (stateNext == FINISH) frame_count <= frame_count + FRAME_W'(1);
      // The starting tick is taken in IDLE; any tick seen outside IDLE is dropped.
      if (frame_tick && (state != IDLE)) overrun <= 1'b1;
      if (stageTimeout) timeout_err <= 1'b1;
    end
  end

endmodule

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
- Frame-level controller for the sprite-drawing datapath.
- On each frame tick it clears the datapath's done flags, then steps through the draw stages in a fixed order: background, left player, right player, ball, left goal, right goal, ground.
- For each stage it asserts exactly one draw request and waits for the matching done flag.
- A per-stage watchdog guards against a stalled stage. Status outputs report frame completion, overrun and timeout.

Parameters:
- TIMEOUT_CYCLES, 131072, maximum cycles allowed in any draw stage before it is abandoned. Must exceed the 76800-pixel background fill.
- FRAME_W, 8, width of the completed-frame counter.

Ports:
- Clock  in  1  system clock
- Resetn  in  1  synchronous, active-low reset
- enable  in  1  when low, new frames are not started; a frame already in progress still finishes
- frame_tick  in  1  single-cycle start-of-frame strobe (~60 Hz)
- done_bg, done_lp, done_rp, done_ball, done_lg, done_rg, done_gnd  in  1 each  datapath stage-done flags (level)
- draw_bg, draw_lp, draw_rp, draw_ball, draw_lg, draw_rg, draw_gnd  out  1 each  stage draw requests (level)
- dp_clear  out  1  one-cycle pulse; makes the datapath clear its done flags and counters
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse when FINISH is entered
- frame_count  out  FRAME_W  number of completed frames; wraps modulo 2^FRAME_W
- overrun  out  1  sticky; set by a frame_tick that arrives while busy
- timeout_err  out  1  sticky; set when any stage times out

Behaviour:
- Reset (Resetn low at a Clock edge):
  - state = IDLE.
  - All draw_* = 0, dp_clear = 0, busy = 0, frame_done = 0.
  - frame_count = 0, overrun = 0, timeout_err = 0, watchdog = 0.
  - Reset mid-frame aborts immediately; no outputs linger.
- All outputs are registered; they change on the clock edge after the state transition.
- States and transitions:
  - IDLE → CLR when frame_tick && enable.
  - CLR: dp_clear = 1 for exactly this one cycle → CLRW.
  - CLRW: one settling cycle so the done flags read low → BG.
  - BG → LP → RP → BALL → LG → RG → GND → FINISH.
  - In each stage, only the corresponding draw_* is high.
  - A stage advances on the first cycle its done_* is sampled high. The next stage's draw_* goes high on the following edge.
  - Stage latency = datapath time + 1 cycle; there are no gap cycles between stages.
  - FINISH: frame_done = 1; frame_count increments → IDLE.
- Watchdog:
  - Width is clog2(TIMEOUT_CYCLES).
  - Cleared on entry to every draw stage; increments each cycle in that stage.
  - If it reaches TIMEOUT_CYCLES-1 while done_* is low: set timeout_err and advance to the next stage as if done.
  - If done_* is high on that same cycle, it is a normal advance and timeout_err is not set.
- frame_tick while busy:
  - Ignored; no tick is queued.
  - Sets overrun, including on the cycle the controller leaves IDLE? No: a tick on the IDLE→CLR cycle is the starting tick.
  - A tick in FINISH sets overrun and is dropped.
- enable:
  - Sampled only in IDLE.
  - Deasserting it mid-frame does not abort the frame.
- Done flags that are already high at stage entry, i.e. stale because CLR failed, advance after one cycle. This is legal behaviour; the bench flags it as an error.
- Exactly one of draw_* and dp_clear is high at any time (one-hot or all zero).
- frame_count wraps from 2^FRAME_W-1 to 0 with no flag.
- Sticky flags clear only on reset.

Decomposition:
- Shared package holds:
  - state enum: IDLE, CLR, CLRW, BG, LP, RP, BALL, LG, RG, GND, FINISH;
  - stage-index constants 0..6;
  - default TIMEOUT_CYCLES.
- One natural sub-module: stage_watchdog (loadable up-counter with terminal-count output), reused per stage via clear-on-entry.
- Stage outputs are decoded from state.

Test Plan:
- Nominal frame: enable=1, one frame_tick; a datapath model raises each done 5 cycles after its draw.
  - Expect: dp_clear for 1 cycle.
  - Expect: draw_bg through draw_gnd high in order, each for 6 cycles.
  - Expect: frame_done pulse and frame_count=1. busy drops after FINISH.
- Overrun: a second frame_tick during the LP stage.
  - Expect: overrun=1, the frame completes normally, no second frame starts, frame_count=1.
- Timeout: TIMEOUT_CYCLES=16; done_ball is never asserted.
  - Expect: draw_ball high for exactly 16 cycles, timeout_err=1, the LG stage follows, frame_done still pulses.
- Reset mid-frame: Resetn=0 for 1 cycle during RG.
  - Expect: the next cycle has all outputs 0 and state IDLE. The next tick starts a full frame from CLR.
- Enable gating: enable=0 with a tick in IDLE means no activity.
  - Dropping enable during BG still completes the frame.
  - With FRAME_W=2, four frames leave frame_count=0 (wrap).
